// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI write arbiter: response codes, AW FSM states,
// the captured AW beat and the round-robin picker.
package axi_arb_pkg;

    // The AW beat is held at the widest supported size; users slice their own widths out.
    localparam int unsigned AW_ADDR_MAX = 64;
    localparam int unsigned AW_ID_MAX   = 20;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic {
        StIdle,
        StHold
    } aw_state_e;

    typedef struct packed {
        logic [AW_ADDR_MAX-1:0] addr;
        logic [AW_ID_MAX-1:0]   id;
        logic [7:0]             len;
        logic [3:0]             qos;
    } aw_beat_t;

    // First set bit at or after ptr. Bits at or above the port count must be zero,
    // so wrapping modulo 16 is the same as wrapping modulo the port count.
    function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr);
        logic [3:0] idx;
        rr_pick = ptr;
        for (int i = 15; i >= 0; i--) begin
            idx = ptr + 4'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/axi_arb_fifo.sv
// Synchronous FIFO with asynchronous active-high reset. DEPTH must be a power of two, >= 2.
module axi_arb_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI4 write arbiter: round-robin AW grant, W routed in grant order, B routed by ID prefix.
// Define AXI_ARB_QOS_EN to let only the highest-s_awqos requesters compete for each grant.
module axi_wr_arbiter #(
    parameter int unsigned NUM_MST = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic                                    aclk,
    input  logic                                    areset,

    input  logic [NUM_MST-1:0]                      s_awvalid,
    output logic [NUM_MST-1:0]                      s_awready,
    input  logic [NUM_MST*ADDR_W-1:0]               s_awaddr,
    input  logic [NUM_MST*ID_W-1:0]                 s_awid,
    input  logic [NUM_MST*8-1:0]                    s_awlen,
    input  logic [NUM_MST*4-1:0]                    s_awqos,

    input  logic [NUM_MST-1:0]                      s_wvalid,
    output logic [NUM_MST-1:0]                      s_wready,
    input  logic [NUM_MST*DATA_W-1:0]               s_wdata,
    input  logic [NUM_MST*(DATA_W/8)-1:0]           s_wstrb,
    input  logic [NUM_MST-1:0]                      s_wlast,

    output logic [NUM_MST-1:0]                      s_bvalid,
    input  logic [NUM_MST-1:0]                      s_bready,
    output logic [NUM_MST*ID_W-1:0]                 s_bid,
    output logic [NUM_MST*2-1:0]                    s_bresp,

    output logic                                    m_awvalid,
    input  logic                                    m_awready,
    output logic [ADDR_W-1:0]                       m_awaddr,
    output logic [ID_W+$clog2(NUM_MST)-1:0]         m_awid,
    output logic [7:0]                              m_awlen,
    output logic [3:0]                              m_awqos,

    output logic                                    m_wvalid,
    input  logic                                    m_wready,
    output logic [DATA_W-1:0]                       m_wdata,
    output logic [DATA_W/8-1:0]                     m_wstrb,
    output logic                                    m_wlast,

    input  logic                                    m_bvalid,
    output logic                                    m_bready,
    input  logic [ID_W+$clog2(NUM_MST)-1:0]         m_bid,
    input  logic [1:0]                              m_bresp
);

    import axi_arb_pkg::*;

    localparam int unsigned IDX_W  = $clog2(NUM_MST);
    localparam int unsigned MID_W  = ID_W + IDX_W;
    localparam int unsigned STRB_W = DATA_W / 8;

    aw_state_e        state_q, state_d;
    aw_beat_t         beat_q, beat_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_MST-1:0] eligible;
    logic [IDX_W-1:0] winner;
    logic             grant;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [IDX_W-1:0] fifo_head;
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] b_port;
    logic             unused_beat;

`ifdef AXI_ARB_QOS_EN
    logic [3:0] top_qos;

    always_comb begin
        top_qos  = '0;
        eligible = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (s_awvalid[i] && (s_awqos[i*4 +: 4] > top_qos)) begin
                top_qos = s_awqos[i*4 +: 4];
            end
        end
        for (int i = 0; i < NUM_MST; i++) begin
            eligible[i] = s_awvalid[i] && (s_awqos[i*4 +: 4] == top_qos);
        end
    end
`else
    assign eligible = s_awvalid;
`endif

    assign winner = IDX_W'(rr_pick(16'(eligible), 4'(rr_ptr_q)));
    // Full is sampled before any same-cycle pop, so a pop never frees a slot for this cycle.
    assign grant  = (state_q == StIdle) && (|s_awvalid) && !fifo_full && !areset;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rr_ptr_d  = rr_ptr_q;
        s_awready = '0;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    s_awready[winner] = 1'b1;
                    beat_d.addr = AW_ADDR_MAX'(s_awaddr[winner*ADDR_W +: ADDR_W]);
                    beat_d.id   = AW_ID_MAX'({winner, s_awid[winner*ID_W +: ID_W]});
                    beat_d.len  = s_awlen[winner*8 +: 8];
                    beat_d.qos  = s_awqos[winner*4 +: 4];
                    rr_ptr_d    = (32'(winner) == NUM_MST - 1) ? '0 : winner + 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (m_awready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign m_awvalid   = (state_q == StHold);
    assign m_awaddr    = beat_q.addr[ADDR_W-1:0];
    assign m_awid      = beat_q.id[MID_W-1:0];
    assign m_awlen     = beat_q.len;
    assign m_awqos     = beat_q.qos;
    assign unused_beat = ^beat_q;

    // Grant order: the head owns the W channel until its last beat is accepted.
    axi_arb_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUT)
    ) u_order_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (grant),
        .pop   (fifo_pop),
        .din   (winner),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = fifo_empty ? '0 : fifo_head;

    always_comb begin
        m_wvalid = !fifo_empty && s_wvalid[head];
        m_wdata  = s_wdata[head*DATA_W +: DATA_W];
        m_wstrb  = s_wstrb[head*STRB_W +: STRB_W];
        m_wlast  = s_wlast[head];
        s_wready = '0;
        if (!fifo_empty) begin
            s_wready[head] = m_wready;
        end
    end

    assign fifo_pop = m_wvalid && m_wready && m_wlast;

    assign b_port = m_bid[MID_W-1:ID_W];

    // Responses tagged with a port index that does not exist are drained and dropped.
    always_comb begin
        s_bvalid = '0;
        m_bready = 1'b1;
        if (32'(b_port) < NUM_MST) begin
            s_bvalid[b_port] = m_bvalid;
            m_bready         = s_bready[b_port];
        end
    end

    assign s_bid   = {NUM_MST{m_bid[ID_W-1:0]}};
    assign s_bresp = {NUM_MST{m_bresp}};

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: directed scenarios plus randomized rounds
// checked against a round-robin/QoS reference model and a grant-order queue.
module tb_axi_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int IX = 2;
    localparam int SW = DW / 8;

    logic              aclk;
    logic              areset;
    logic [N-1:0]      s_awvalid, s_awready;
    logic [N*AW-1:0]   s_awaddr;
    logic [N*IW-1:0]   s_awid;
    logic [N*8-1:0]    s_awlen;
    logic [N*4-1:0]    s_awqos;
    logic [N-1:0]      s_wvalid, s_wready, s_wlast;
    logic [N*DW-1:0]   s_wdata;
    logic [N*SW-1:0]   s_wstrb;
    logic [N-1:0]      s_bvalid, s_bready;
    logic [N*IW-1:0]   s_bid;
    logic [N*2-1:0]    s_bresp;
    logic              m_awvalid, m_awready;
    logic [AW-1:0]     m_awaddr;
    logic [IW+IX-1:0]  m_awid;
    logic [7:0]        m_awlen;
    logic [3:0]        m_awqos;
    logic              m_wvalid, m_wready, m_wlast;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_bvalid, m_bready;
    logic [IW+IX-1:0]  m_bid;
    logic [1:0]        m_bresp;

    axi_wr_arbiter #(
        .NUM_MST (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ID_W    (IW),
        .MAX_OUT (8)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_awid    (s_awid),
        .s_awlen   (s_awlen),
        .s_awqos   (s_awqos),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_awaddr  (m_awaddr),
        .m_awid    (m_awid),
        .m_awlen   (m_awlen),
        .m_awqos   (m_awqos),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_bid     (m_bid),
        .m_bresp   (m_bresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vectors;
    int miscompares;
    int rr_m;
    int ord_p[$];
    int ord_len[$];
    logic [AW-1:0] ea_addr [N];
    logic [IW-1:0] ea_id [N];
    int            ea_len [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: highest QoS among requesters (if enabled), then first from ptr.
    function automatic int model_winner(input logic [N-1:0] req, input logic [4*N-1:0] qos,
                                        input int ptr);
        int best;
        int top;
        best = -1;
        top  = 0;
`ifdef AXI_ARB_QOS_EN
        for (int i = 0; i < N; i++) begin
            if (req[i] && int'(qos[i*4 +: 4]) > top) top = int'(qos[i*4 +: 4]);
        end
`endif
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (best < 0 && req[i] && int'(qos[i*4 +: 4]) >= top) best = i;
        end
        return best;
    endfunction

    task automatic clear_inputs();
        s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awqos = '0;
        s_wvalid  = '0; s_wdata  = '0; s_wstrb = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_inputs();
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        rr_m = 0;
        ord_p.delete();
        ord_len.delete();
    endtask

    task automatic set_aw(input int p, input int len, input int qos);
        ea_addr[p] = $urandom;
        ea_id[p]   = 4'($urandom);
        ea_len[p]  = (len < 0) ? int'($urandom_range(0, 3)) : len;
        s_awaddr[p*AW +: AW] = ea_addr[p];
        s_awid[p*IW +: IW]   = ea_id[p];
        s_awlen[p*8 +: 8]    = 8'(ea_len[p]);
        s_awqos[p*4 +: 4]    = 4'(qos);
        s_awvalid[p]         = 1'b1;
    endtask

    // Entered just after a falling edge; returns on the falling edge after the AW handshake.
    task automatic do_grant(input int g, input int budget, input bit drop);
        int n;
        n = 0;
        #2;
        while (s_awready === '0 && n < budget) begin
            @(negedge aclk);
            #2;
            n++;
        end
        chk("aw_grant", 64'(s_awready), 64'(1) << g);
        @(negedge aclk);
        if (drop) s_awvalid[g] = 1'b0;
        #2;
        chk("m_awvalid", 64'(m_awvalid), 64'(1));
        chk("m_awid", 64'(m_awid), 64'((g << IW) | int'(ea_id[g])));
        chk("m_awaddr", 64'(m_awaddr), 64'(ea_addr[g]));
        chk("m_awlen", 64'(m_awlen), 64'(ea_len[g]));
        ord_p.push_back(g);
        ord_len.push_back(ea_len[g]);
        rr_m = (g + 1) % N;
        @(negedge aclk);
    endtask

    // Port p sends nb beats of a total-beat burst; every other port offers junk W beats.
    task automatic send_w(input int p, input int nb, input int total);
        for (int b = 0; b < nb; b++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            for (int q = 0; q < N; q++) begin
                s_wvalid[q]          = 1'b1;
                s_wdata[q*DW +: DW]  = (q == p) ? d : d ^ 64'(q + 1);
                s_wstrb[q*SW +: SW]  = (q == p) ? 8'hA5 : 8'h0F;
                s_wlast[q]           = (q != p) || (b == total - 1);
            end
            #2;
            chk("m_wvalid", 64'(m_wvalid), 64'(1));
            chk("m_wdata", m_wdata, d);
            chk("m_wstrb", 64'(m_wstrb), 64'(8'hA5));
            chk("m_wlast", 64'(m_wlast), 64'(b == total - 1));
            chk("s_wready", 64'(s_wready), 64'(1) << p);
            @(negedge aclk);
        end
        s_wvalid = '0;
        s_wlast  = '0;
    endtask

    task automatic drain_w();
        int p;
        int l;
        while (ord_p.size() > 0) begin
            p = ord_p.pop_front();
            l = ord_len.pop_front();
            send_w(p, l + 1, l + 1);
        end
    endtask

    task automatic send_b(input int p, input logic [IW-1:0] id);
        logic [1:0]   r;
        logic [N-1:0] rdy;
        int           q;
        r   = 2'($urandom);
        rdy = 4'($urandom);
        q   = int'($urandom_range(0, N - 1));
        m_bvalid = 1'b1;
        m_bid    = 6'((p << IW) | int'(id));
        m_bresp  = r;
        s_bready = rdy;
        #2;
        chk("s_bvalid", 64'(s_bvalid), 64'(1) << p);
        chk("m_bready", 64'(m_bready), 64'(rdy[p]));
        chk("s_bid", 64'(s_bid[q*IW +: IW]), 64'(id));
        chk("s_bresp", 64'(s_bresp[q*2 +: 2]), 64'(r));
        @(negedge aclk);
        m_bvalid = 1'b0;
        s_bready = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int p;
        int l;
        int q_ord[$];
        logic [N-1:0] mask;
        vectors     = 0;
        miscompares = 0;

        // Reset values, with requests and W beats already offered.
        areset = 1'b1;
        clear_inputs();
        s_awvalid = '1;
        s_wvalid  = '1;
        @(negedge aclk);
        @(negedge aclk);
        #2;
        chk("rst_s_awready", 64'(s_awready), 64'(0));
        chk("rst_m_awvalid", 64'(m_awvalid), 64'(0));
        chk("rst_m_wvalid", 64'(m_wvalid), 64'(0));
        chk("rst_s_wready", 64'(s_wready), 64'(0));
        chk("rst_m_awid", 64'(m_awid), 64'(0));
        chk("rst_m_awaddr", 64'(m_awaddr), 64'(0));
        do_reset();

        // Single burst from port 1.
        set_aw(1, 3, 0);
        do_grant(1, 4, 1'b1);
        drain_w();
        send_b(1, ea_id[1]);

        // Contention: all ports requesting from reset.
        areset = 1'b1;
        clear_inputs();
        for (int i = 0; i < N; i++) set_aw(i, 0, 0);
        @(negedge aclk);
        areset = 1'b0;
        rr_m = 0;
        ord_p.delete();
        ord_len.delete();
        for (int k = 0; k < 5; k++) do_grant(model_winner(s_awvalid, s_awqos, rr_m), 4, 1'b0);
        s_awvalid = '0;
        drain_w();

        // FIFO full: eight grants with W withheld, ninth waits for a wlast.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            p = int'($urandom_range(0, N - 1));
            set_aw(p, -1, 0);
            do_grant(p, 4, 1'b1);
        end
        p = int'($urandom_range(0, N - 1));
        set_aw(p, -1, 0);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("full_no_grant", 64'(s_awready), 64'(0));
            @(negedge aclk);
        end
        l = ord_len.pop_front();
        send_w(ord_p.pop_front(), l + 1, l + 1);
        do_grant(p, 2, 1'b1);
        drain_w();

        // AW backpressure: fields stable, no other grant while held.
        do_reset();
        m_awready = 1'b0;
        set_aw(3, -1, 0);
        do_grant(3, 4, 1'b1);
        set_aw(0, -1, 0);
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("bp_m_awvalid", 64'(m_awvalid), 64'(1));
            chk("bp_m_awaddr", 64'(m_awaddr), 64'(ea_addr[3]));
            chk("bp_m_awid", 64'(m_awid), 64'((3 << IW) | int'(ea_id[3])));
            chk("bp_s_awready", 64'(s_awready), 64'(0));
            @(negedge aclk);
        end
        m_awready = 1'b1;
        do_grant(model_winner(s_awvalid, s_awqos, rr_m), 4, 1'b1);
        drain_w();

        // QoS: port 0 qos=1 vs port 2 qos=7 with the pointer at 0.
        do_reset();
        set_aw(0, -1, 1);
        set_aw(2, -1, 7);
`ifdef AXI_ARB_QOS_EN
        do_grant(2, 4, 1'b1);
        do_grant(0, 4, 1'b1);
`else
        do_grant(0, 4, 1'b1);
        do_grant(2, 4, 1'b1);
`endif
        drain_w();

        // Reset in the middle of a 4-beat burst, with a second AW held downstream.
        do_reset();
        set_aw(1, 3, 0);
        do_grant(1, 4, 1'b1);
        m_awready = 1'b0;
        set_aw(2, 0, 0);
        send_w(1, 2, 4);
        s_wvalid[1] = 1'b1;
        #1;
        chk("pre_rst_m_awvalid", 64'(m_awvalid), 64'(1));
        chk("pre_rst_m_wvalid", 64'(m_wvalid), 64'(1));
        areset = 1'b1;
        #1;
        chk("mid_rst_m_awvalid", 64'(m_awvalid), 64'(0));
        chk("mid_rst_m_wvalid", 64'(m_wvalid), 64'(0));
        chk("mid_rst_s_wready", 64'(s_wready), 64'(0));
        chk("mid_rst_s_awready", 64'(s_awready), 64'(0));
        chk("mid_rst_m_awaddr", 64'(m_awaddr), 64'(0));
        @(negedge aclk);
        do_reset();
        set_aw(1, 1, 0);
        do_grant(1, 4, 1'b1);
        drain_w();
        send_b(1, ea_id[1]);

        // Randomized rounds against the reference model.
        for (int r = 0; r < 12; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) set_aw(i, -1, int'($urandom_range(0, 15)));
            end
            while (s_awvalid != '0) begin
                do_grant(model_winner(s_awvalid, s_awqos, rr_m), 4, 1'b1);
            end
            q_ord = ord_p;
            drain_w();
            foreach (q_ord[k]) send_b(q_ord[k], ea_id[q_ord[k]]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
